mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 85 ++++++++
 rtl/mc_if.sv | 32 +++
 rtl/mc_out_decode.sv | 88 ++++++++
 rtl/mc_controller.sv | 70 +++++++
 tb/tb_mc_controller.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// MC_JAL_EN enables the jal opcode in the dispatch function.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRtExe,
        StRtWb,
        StBeq,
        StJump,
        StIExe,
        StIWb,
        StJal
    } mc_state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluSub  = 2'b01;
    localparam logic [1:0] AluFunc = 2'b10;
    localparam logic [1:0] AluSlt  = 2'b11;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBBranch = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcTarget = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMem = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       illegal;
    } mc_ctrl_t;

    // StFetch doubles as the "unknown opcode" result.
    function automatic mc_state_e dispatch(input logic [5:0] op);
        mc_state_e nxt;
        case (op)
            OpRtype:      nxt = StRtExe;
            OpLw, OpSw:   nxt = StMemAdr;
            OpBeq:        nxt = StBeq;
            OpJ:          nxt = StJump;
            OpAddi, OpSlti: nxt = StIExe;
`ifdef MC_JAL_EN
            OpJal:        nxt = StJal;
`endif
            default:      nxt = StFetch;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Control/status bundle between the datapath (master) and mc_controller (slave).
interface mc_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_source;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [31:0] instr_count;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
        input  alu_src_b, pc_source, reg_dst, mem_to_reg, alu_op, illegal, instr_count
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
        output alu_src_b, pc_source, reg_dst, mem_to_reg, alu_op, illegal, instr_count
    );
endinterface

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode; everything forced to 0 while rst is high.
// The JAL state outputs exist only when MC_JAL_EN is defined.
module mc_out_decode
    import mc_pkg::*;
(
    input  logic      rst,
    input  mc_state_e state,
    input  logic [5:0] opcode,
    input  logic      zero,
    input  logic      mem_ready,
    output mc_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBBranch;
                ctrl.illegal   = (dispatch(opcode) == StFetch);
            end
            StMemAdr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RegDstRt;
                ctrl.mem_to_reg = MemToRegMem;
            end
            StRtExe: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluFunc;
            end
            StRtWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RegDstRd;
            end
            StBeq: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluSub;
                ctrl.pc_source = PcTarget;
                ctrl.pc_write  = zero;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcJump;
            end
            StIExe: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = (opcode == OpSlti) ? AluSlt : AluAdd;
            end
            StIWb: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MC_JAL_EN
            StJal: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RegDstRa;
                ctrl.mem_to_reg = MemToRegPc;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PcJump;
            end
`endif
            default: ;
        endcase
        if (rst) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM with fetch counter; state register and next-state here,
// control decode in mc_out_decode. MC_JAL_EN adds the jal instruction.
module mc_controller
    import mc_pkg::*;
(
    input logic clk,
    input logic rst,
    mc_if.slave bus
);

    mc_state_e   state_q, state_d;
    logic [31:0] count_q;
    mc_ctrl_t    ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: state_d = dispatch(bus.opcode);
            StMemAdr: state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWr:  if (bus.mem_ready) state_d = StFetch;
            StRtExe:  state_d = StRtWb;
            StIExe:   state_d = StIWb;
            default:  state_d = StFetch;
        endcase
    end

    // Wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == StFetch && bus.mem_ready) begin
            count_q <= count_q + 32'd1;
        end
    end

    mc_out_decode u_out_decode (
        .rst      (rst),
        .state    (state_q),
        .opcode   (bus.opcode),
        .zero     (bus.zero),
        .mem_ready(bus.mem_ready),
        .ctrl     (ctrl)
    );

    assign bus.pc_write    = ctrl.pc_write;
    assign bus.iord        = ctrl.iord;
    assign bus.mem_read    = ctrl.mem_read;
    assign bus.mem_write   = ctrl.mem_write;
    assign bus.ir_write    = ctrl.ir_write;
    assign bus.reg_write   = ctrl.reg_write;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.pc_source   = ctrl.pc_source;
    assign bus.reg_dst     = ctrl.reg_dst;
    assign bus.mem_to_reg  = ctrl.mem_to_reg;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.illegal     = ctrl.illegal;
    assign bus.instr_count = rst ? 32'd0 : count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected controls queued, then compared.
// Build with MC_JAL_EN defined to exercise jal; otherwise jal is checked as illegal.
module tb_mc_controller;

    logic clk;
    logic rst;
    mc_if bus ();

    mc_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write,iord,mem_read,mem_write,ir_write,reg_write,alu_src_a,
    //  alu_src_b,pc_source,reg_dst,mem_to_reg,alu_op,illegal}
    localparam logic [17:0] E_ZERO      = 18'b0_0_0_0_0_0_0_00_00_00_00_00_0;
    localparam logic [17:0] E_FETCH_RDY = 18'b1_0_1_0_1_0_0_01_00_00_00_00_0;
    localparam logic [17:0] E_FETCH_WT  = 18'b0_0_1_0_0_0_0_01_00_00_00_00_0;
    localparam logic [17:0] E_DECODE    = 18'b0_0_0_0_0_0_0_11_00_00_00_00_0;
    localparam logic [17:0] E_ILLEGAL   = 18'b0_0_0_0_0_0_0_11_00_00_00_00_1;
    localparam logic [17:0] E_MEMADR    = 18'b0_0_0_0_0_0_1_10_00_00_00_00_0;
    localparam logic [17:0] E_MEMRD     = 18'b0_1_1_0_0_0_0_00_00_00_00_00_0;
    localparam logic [17:0] E_MEMWR     = 18'b0_1_0_1_0_0_0_00_00_00_00_00_0;
    localparam logic [17:0] E_MEMWB     = 18'b0_0_0_0_0_1_0_00_00_00_01_00_0;
    localparam logic [17:0] E_RTEXE     = 18'b0_0_0_0_0_0_1_00_00_00_00_10_0;
    localparam logic [17:0] E_RTWB      = 18'b0_0_0_0_0_1_0_00_00_01_00_00_0;
    localparam logic [17:0] E_BEQ_T     = 18'b1_0_0_0_0_0_1_00_01_00_00_01_0;
    localparam logic [17:0] E_BEQ_N     = 18'b0_0_0_0_0_0_1_00_01_00_00_01_0;
    localparam logic [17:0] E_JUMP      = 18'b1_0_0_0_0_0_0_00_10_00_00_00_0;
    localparam logic [17:0] E_IEXE_ADD  = 18'b0_0_0_0_0_0_1_10_00_00_00_00_0;
    localparam logic [17:0] E_IEXE_SLT  = 18'b0_0_0_0_0_0_1_10_00_00_00_11_0;
    localparam logic [17:0] E_IWB       = 18'b0_0_0_0_0_1_0_00_00_00_00_00_0;
    localparam logic [17:0] E_JAL       = 18'b1_0_0_0_0_1_0_00_10_10_10_00_0;

    typedef struct {
        logic        r;
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [17:0] ctrl;
        logic [31:0] cnt;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] exp_cnt;
    int          checks;
    int          errors;

    function automatic logic [17:0] observed();
        return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.reg_dst,
                bus.mem_to_reg, bus.alu_op, bus.illegal};
    endfunction

    // Queue one cycle of stimulus with its expected outputs; tracks the fetch count.
    function automatic void push(logic r, logic mr, logic z, logic [5:0] op, logic [17:0] c);
        ent_t e;
        e.r = r; e.mr = mr; e.z = z; e.op = op; e.ctrl = c;
        e.cnt = r ? 32'd0 : exp_cnt;
        sb.push_back(e);
        if (r) exp_cnt = 32'd0;
        else if (c[13]) exp_cnt = exp_cnt + 32'd1;
    endfunction

    task automatic test_reset();
        ent_t e;
        push(1, 1, 1, 6'b000000, E_ZERO);
        push(1, 1, 1, 6'b100011, E_ZERO);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL reset ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL reset count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        ent_t e;
        push(0, 1, 0, 6'b000000, E_FETCH_RDY);
        push(0, 1, 0, 6'b000000, E_DECODE);
        push(0, 1, 0, 6'b000000, E_RTEXE);
        push(0, 1, 0, 6'b000000, E_RTWB);
        push(0, 0, 0, 6'b000000, E_FETCH_WT);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL rtype ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL rtype count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        ent_t e;
        // lw with two stall cycles in MEMRD: 7 cycles
        push(0, 1, 0, 6'b100011, E_FETCH_RDY);
        push(0, 1, 0, 6'b100011, E_DECODE);
        push(0, 1, 0, 6'b100011, E_MEMADR);
        push(0, 0, 0, 6'b100011, E_MEMRD);
        push(0, 0, 0, 6'b100011, E_MEMRD);
        push(0, 1, 0, 6'b100011, E_MEMRD);
        push(0, 1, 0, 6'b100011, E_MEMWB);
        // sw with a fetch stall and a write stall
        push(0, 0, 0, 6'b101011, E_FETCH_WT);
        push(0, 1, 0, 6'b101011, E_FETCH_RDY);
        push(0, 1, 0, 6'b101011, E_DECODE);
        push(0, 1, 0, 6'b101011, E_MEMADR);
        push(0, 0, 0, 6'b101011, E_MEMWR);
        push(0, 1, 0, 6'b101011, E_MEMWR);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL mem ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL mem count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        ent_t e;
        push(0, 1, 0, 6'b000100, E_FETCH_RDY);
        push(0, 1, 0, 6'b000100, E_DECODE);
        push(0, 1, 1, 6'b000100, E_BEQ_T);
        push(0, 1, 1, 6'b000100, E_FETCH_RDY);
        push(0, 1, 1, 6'b000100, E_DECODE);
        push(0, 1, 0, 6'b000100, E_BEQ_N);
        push(0, 1, 0, 6'b000010, E_FETCH_RDY);
        push(0, 1, 0, 6'b000010, E_DECODE);
        push(0, 1, 0, 6'b000010, E_JUMP);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL branch ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL branch count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        ent_t e;
        push(0, 1, 0, 6'b001000, E_FETCH_RDY);
        push(0, 1, 0, 6'b001000, E_DECODE);
        push(0, 1, 0, 6'b001000, E_IEXE_ADD);
        push(0, 1, 0, 6'b001000, E_IWB);
        push(0, 1, 0, 6'b001010, E_FETCH_RDY);
        push(0, 1, 0, 6'b001010, E_DECODE);
        push(0, 1, 0, 6'b001010, E_IEXE_SLT);
        push(0, 1, 0, 6'b001010, E_IWB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL itype ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL itype count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_jal();
        ent_t e;
        push(0, 1, 0, 6'b111111, E_FETCH_RDY);
        push(0, 1, 0, 6'b111111, E_ILLEGAL);
        push(0, 0, 0, 6'b111111, E_FETCH_WT);
        push(0, 1, 0, 6'b000011, E_FETCH_RDY);
`ifdef MC_JAL_EN
        push(0, 1, 0, 6'b000011, E_DECODE);
        push(0, 1, 0, 6'b000011, E_JAL);
`else
        push(0, 1, 0, 6'b000011, E_ILLEGAL);
`endif
        push(0, 0, 0, 6'b000011, E_FETCH_WT);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL illegal ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL illegal count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        ent_t e;
        push(0, 1, 0, 6'b101011, E_FETCH_RDY);
        push(0, 1, 0, 6'b101011, E_DECODE);
        push(0, 1, 0, 6'b101011, E_MEMADR);
        push(0, 0, 0, 6'b101011, E_MEMWR);
        push(1, 1, 0, 6'b101011, E_ZERO);
        push(0, 1, 0, 6'b000010, E_FETCH_RDY);
        push(0, 1, 0, 6'b000010, E_DECODE);
        push(0, 1, 0, 6'b000010, E_JUMP);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.r; bus.mem_ready = e.mr; bus.zero = e.z; bus.opcode = e.op;
            @(negedge clk);
            checks++;
            if (observed() !== e.ctrl) begin
                errors++; $display("FAIL rstmid ctrl: got %b want %b", observed(), e.ctrl);
            end
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL rstmid count: got %0d want %0d", bus.instr_count, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 32'd0;
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.opcode = 6'b000000;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_itype();
        test_illegal_jal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
